// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for bin_to_bcd_seq.
// The overflow signal exists only when BCD_OVERFLOW_EN is defined.
interface bin_to_bcd_seq_if #(
  parameter int unsigned BIN_W = 14
);
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [31:0]      digit_reg;
`ifdef BCD_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output start, bin_in,
    input  busy, done, digit_reg
`ifdef BCD_OVERFLOW_EN
    , overflow
`endif
  );

  modport slave (
    input  start, bin_in,
    output busy, done, digit_reg
`ifdef BCD_OVERFLOW_EN
    , overflow
`endif
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter producing four packed BCD digits.
// Define BCD_OVERFLOW_EN to saturate results above 9999 to 9999 and flag overflow.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk_10Hz,
  input  logic             reset,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [19:0]      scratch_q, scratch_d;
  logic [19:0]      adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      digit_q, digit_d;
  logic             done_q, done_d;
`ifdef BCD_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    done_d    = 1'b0;
    adj       = scratch_q;
`ifdef BCD_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    // Add-3 correction on every nibble in parallel, ahead of the shift.
    for (int unsigned i = 0; i < 5; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d   = bus.bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shreg_d} = {adj, shreg_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        digit_d = scratch_q[15:0];
`ifdef BCD_OVERFLOW_EN
        if (scratch_q[19:16] != 4'd0) begin
          digit_d = 16'h9999;
          ovf_d   = 1'b1;
        end else begin
          ovf_d   = 1'b0;
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_10Hz or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      digit_q   <= '0;
      done_q    <= 1'b0;
`ifdef BCD_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      done_q    <= done_d;
`ifdef BCD_OVERFLOW_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.digit_reg = {16'h0000, digit_q};
`ifdef BCD_OVERFLOW_EN
  assign bus.overflow  = ovf_q;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W = 14).
module tb_bin_to_bcd_seq;
  localparam int unsigned BIN_W = 14;

  logic clk_10Hz = 1'b0;
  logic reset    = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_10Hz = ~clk_10Hz;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk_10Hz (clk_10Hz),
    .reset    (reset),
    .bus      (bus.slave)
  );

  // Drive a one-edge start; returns #1 after the accepting edge.
  task automatic pulse_start(input logic [13:0] v);
    @(negedge clk_10Hz);
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(posedge clk_10Hz);
    #1;
    bus.start  = 1'b0;
    bus.bin_in = 14'h3FFF;
  endtask

  // Convert v; lat = edges after the accepting edge until done, bcnt = busy samples.
  task automatic convert(input logic [13:0] v, output logic [31:0] res,
                         output int lat, output int bcnt);
    bit got;
    got  = 1'b0;
    lat  = 0;
    bcnt = 0;
    pulse_start(v);
    while (lat < 40 && !got) begin
      if (bus.busy) bcnt++;
      @(posedge clk_10Hz);
      #1;
      lat++;
      if (bus.done) got = 1'b1;
    end
    res = bus.digit_reg;
  endtask

  task automatic test_reset;
    #12;
    n_checks++; if (bus.digit_reg !== 32'h0) begin n_fail++; $display("FAIL reset_digit got=%h exp=%h", bus.digit_reg, 32'h0); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    @(negedge clk_10Hz);
    reset = 1'b1;
    repeat (5) @(posedge clk_10Hz);
    #1;
    n_checks++; if (bus.digit_reg !== 32'h0) begin n_fail++; $display("FAIL post_reset_digit got=%h exp=%h", bus.digit_reg, 32'h0); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_basic;
    logic [31:0] res;
    int lat, bcnt;
    convert(14'd1234, res, lat, bcnt);
    n_checks++; if (res !== 32'h0000_1234) begin n_fail++; $display("FAIL basic_digit got=%h exp=%h", res, 32'h0000_1234); end
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL basic_latency got=%0d exp=15", lat); end
    n_checks++; if (bcnt !== 15) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=15", bcnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall got=%b exp=0", bus.busy); end
    @(posedge clk_10Hz);
    #1;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got=%b exp=0", bus.done); end
    repeat (5) @(posedge clk_10Hz);
    #1;
    n_checks++; if (bus.digit_reg !== 32'h0000_1234) begin n_fail++; $display("FAIL basic_hold got=%h exp=%h", bus.digit_reg, 32'h0000_1234); end
  endtask

  task automatic test_corners;
    logic [13:0] vin [4]  = '{14'd0, 14'd9999, 14'd1000, 14'd5};
    logic [31:0] vexp [4] = '{32'h0000_0000, 32'h0000_9999, 32'h0000_1000, 32'h0000_0005};
    logic [31:0] res;
    int lat, bcnt;
    for (int i = 0; i < 4; i++) begin
      convert(vin[i], res, lat, bcnt);
      n_checks++; if (res !== vexp[i]) begin n_fail++; $display("FAIL corner_%0d got=%h exp=%h", vin[i], res, vexp[i]); end
      n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL corner_lat_%0d got=%0d exp=15", vin[i], lat); end
`ifdef BCD_OVERFLOW_EN
      n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL corner_ovf_%0d got=%b exp=0", vin[i], bus.overflow); end
`endif
    end
  endtask

  // Extra starts at edge 5 (mid-shift) and edge 15 (DONE edge) must be dropped.
  task automatic test_ignored_start;
    int dones, done_edge;
    logic [31:0] res;
    dones = 0; done_edge = -1; res = '0;
    pulse_start(14'd4321);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_10Hz);
      bus.start  = (k == 5 || k == 15);
      bus.bin_in = 14'd7777;
      @(posedge clk_10Hz);
      #1;
      if (bus.done) begin
        dones++;
        done_edge = k;
        res = bus.digit_reg;
      end
    end
    bus.start = 1'b0;
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL ignored_done_count got=%0d exp=1", dones); end
    n_checks++; if (done_edge !== 15) begin n_fail++; $display("FAIL ignored_done_edge got=%0d exp=15", done_edge); end
    n_checks++; if (res !== 32'h0000_4321) begin n_fail++; $display("FAIL ignored_digit got=%h exp=%h", res, 32'h0000_4321); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignored_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_abort;
    int dones;
    logic [31:0] res;
    int lat, bcnt;
    dones = 0;
    pulse_start(14'd8888);
    repeat (6) @(posedge clk_10Hz);
    @(negedge clk_10Hz);
    reset = 1'b0;
    #1;
    n_checks++; if (bus.digit_reg !== 32'h0) begin n_fail++; $display("FAIL abort_digit got=%h exp=%h", bus.digit_reg, 32'h0); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    repeat (2) @(posedge clk_10Hz);
    @(negedge clk_10Hz);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_10Hz);
      #1;
      if (bus.done) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    n_checks++; if (bus.digit_reg !== 32'h0) begin n_fail++; $display("FAIL abort_hold got=%h exp=%h", bus.digit_reg, 32'h0); end
    convert(14'd42, res, lat, bcnt);
    n_checks++; if (res !== 32'h0000_0042) begin n_fail++; $display("FAIL abort_next got=%h exp=%h", res, 32'h0000_0042); end
  endtask

  task automatic test_overflow;
    logic [31:0] res;
    int lat, bcnt;
    convert(14'd12345, res, lat, bcnt);
`ifdef BCD_OVERFLOW_EN
    n_checks++; if (res !== 32'h0000_9999) begin n_fail++; $display("FAIL ovf_sat got=%h exp=%h", res, 32'h0000_9999); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    repeat (3) @(posedge clk_10Hz);
    #1;
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_hold got=%b exp=1", bus.overflow); end
`else
    n_checks++; if (res !== 32'h0000_2345) begin n_fail++; $display("FAIL ovf_mod got=%h exp=%h", res, 32'h0000_2345); end
`endif
    convert(14'd10, res, lat, bcnt);
    n_checks++; if (res !== 32'h0000_0010) begin n_fail++; $display("FAIL ovf_next got=%h exp=%h", res, 32'h0000_0010); end
`ifdef BCD_OVERFLOW_EN
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
`endif
  endtask

  // Start held high: first accept at edge 1, done at 16, then every 16 edges.
  task automatic test_back_to_back;
    int done_edges[$];
    @(negedge clk_10Hz);
    bus.start  = 1'b1;
    bus.bin_in = 14'd77;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk_10Hz);
      #1;
      if (bus.done) begin
        done_edges.push_back(k);
        n_checks++; if (bus.digit_reg !== 32'h0000_0077) begin n_fail++; $display("FAIL b2b_digit got=%h exp=%h", bus.digit_reg, 32'h0000_0077); end
      end
    end
    bus.start = 1'b0;
    n_checks++; if (done_edges.size() !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", done_edges.size()); end
    if (done_edges.size() >= 2) begin
      n_checks++; if (done_edges[0] !== 16) begin n_fail++; $display("FAIL b2b_first got=%0d exp=16", done_edges[0]); end
      n_checks++; if (done_edges[1] - done_edges[0] !== 16) begin n_fail++; $display("FAIL b2b_period got=%0d exp=16", done_edges[1] - done_edges[0]); end
    end
    repeat (20) @(posedge clk_10Hz);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.bin_in = '0;
    test_reset();
    test_basic();
    test_corners();
    test_ignored_start();
    test_abort();
    test_overflow();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-add-3) that produces the packed-BCD `digit_reg` word consumed by the display digit splitter.
- Takes an unsigned binary value on a start strobe and converts it over BIN_W shift cycles.
- Publishes four BCD digits in `digit_reg[15:0]` with a one-cycle done pulse.
- Runs in the display clock domain and sits between the core's result register and the digit splitter.

Parameters:
- BIN_W, 14, width of the binary input; legal range 4..16.

Ports:
- clk_10Hz  input  1  display clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  conversion request; sampled only while busy=0
- bin_in  input  BIN_W  unsigned binary value; captured on the accepted start edge
- busy  output  1  high while a conversion is in progress (state != IDLE)
- done  output  1  one-cycle pulse, coincident with the digit_reg update
- digit_reg  output  32  [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones; [31:16] always 0
- overflow  output  1  present only with BCD_OVERFLOW_EN

Behaviour:
- Reset, asynchronous while reset=0:
  - state=IDLE, busy=0, done=0.
  - digit_reg=32'h0000_0000, overflow=0.
  - Shift register, 5-digit BCD scratch and counter all cleared.
- Reset mid-conversion aborts the conversion. No done pulse is generated, and digit_reg reads 0 after reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: load bin_in into the shift register, clear the BCD scratch, set cnt=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - Every scratch nibble >=5 gets +3 (all nibbles evaluated in parallel, before the shift).
  - Then {scratch, shreg} shifts left by 1 and cnt increments.
  - When cnt reaches BIN_W-1 on this edge, go to DONE.
- DONE, one edge:
  - digit_reg[15:0] is written from scratch digits 3..0.
  - done=1 for exactly this one cycle.
  - Go to IDLE.
- Latency: start accepted at edge N; digit_reg valid and done=1 after edge N+BIN_W+1. busy rises after edge N and falls after edge N+BIN_W+1.
- start while busy=1, including the DONE cycle, is ignored and not queued.
- bin_in changes after the accepted edge do not affect the result.
- digit_reg holds its last value between conversions. It changes only on the DONE edge or on reset.
- Scratch carries a 5th (ten-thousands) digit so that values >9999 are detected.
- Without the optional feature: digit_reg[15:0] = BCD(bin_in mod 10000). The 5th digit is discarded.
- Back-to-back: start held high continuously gives one conversion per BIN_W+2 edges.

Optional Feature:
- Macro: BCD_OVERFLOW_EN.
- Defined:
  - Port `overflow` exists.
  - On the DONE edge, if the 5th scratch digit != 0: digit_reg[15:0]=16'h9999 (saturate) and overflow=1.
  - Otherwise the normal result is written and overflow=0.
  - overflow is held until the next DONE edge or reset.
- Undefined:
  - No overflow port and no saturation logic.
  - Results follow the mod-10000 rule.

Test Plan:
- Reset:
  - Assert reset=0 mid-run -> digit_reg=0, busy=0, done=0 immediately, without waiting for a clock edge.
  - Release reset -> outputs stay 0 until a start.
- Basic conversion (BIN_W=14):
  - bin_in=1234, 1-cycle start -> busy high for 15 edges.
  - done pulses on edge 15 -> digit_reg=32'h0000_1234.
- Corner values:
  - bin_in=0 -> 32'h0000_0000.
  - bin_in=9999 -> 32'h0000_9999.
  - bin_in=1000 -> 32'h0000_1000.
  - bin_in=5 -> 32'h0000_0005.
- Ignored start:
  - Start with 4321, then pulse start with 7777 at cycle 5 -> single done, digit_reg=32'h0000_4321.
  - Pulse start during DONE -> no new conversion.
- Abort:
  - reset=0 at cycle 7 of a conversion of 8888 -> no done, digit_reg=0.
  - Next conversion of 42 -> 32'h0000_0042.
- Overflow, bin_in=12345:
  - Without BCD_OVERFLOW_EN -> 32'h0000_2345.
  - With BCD_OVERFLOW_EN -> 32'h0000_9999, overflow=1.
  - A following conversion of 10 clears overflow -> overflow=0.
